// File: rtl/uart_rx_top.sv
// UART receiver: 8 data bits LSB first, one parity bit, one stop bit.
// Line is synchronised with two flops and sampled at mid-bit.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | line idle, waiting for rx_s to fall
// S_START | timing half a bit to confirm the start bit at its centre
// S_DATA  | sampling 8 data bits at their centres
// S_PARITY| sampling the parity bit
// S_STOP  | sampling the stop bit and publishing the frame

module uart_rx_top #(
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_data_in,
    output logic [7:0] rx_data_out,
    output logic       rx_valid,
    output logic       rx_parity_err,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t        state, state_nxt;
    logic          rx_meta, rx_s;
    logic [CW-1:0] clk_cnt, clk_cnt_nxt;
    logic [2:0]    bit_cnt, bit_cnt_nxt;
    logic [7:0]    shift_reg, shift_nxt;
    logic          parity_bit, parity_nxt;
    logic [7:0]    data_nxt;
    logic          valid_nxt, perr_nxt, ferr_nxt;

    // Synchroniser resets to the idle level so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_data_in;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            clk_cnt       <= '0;
            bit_cnt       <= '0;
            shift_reg     <= '0;
            parity_bit    <= 1'b0;
            rx_data_out   <= '0;
            rx_valid      <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
        end else begin
            state         <= state_nxt;
            clk_cnt       <= clk_cnt_nxt;
            bit_cnt       <= bit_cnt_nxt;
            shift_reg     <= shift_nxt;
            parity_bit    <= parity_nxt;
            rx_data_out   <= data_nxt;
            rx_valid      <= valid_nxt;
            rx_parity_err <= perr_nxt;
            rx_frame_err  <= ferr_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clk_cnt_nxt = clk_cnt + 1'b1;
        bit_cnt_nxt = bit_cnt;
        shift_nxt   = shift_reg;
        parity_nxt  = parity_bit;
        data_nxt    = rx_data_out;
        valid_nxt   = 1'b0;
        perr_nxt    = rx_parity_err;
        ferr_nxt    = rx_frame_err;

        case (state)
            S_IDLE: begin
                clk_cnt_nxt = '0;
                if (!rx_s) begin
                    state_nxt = S_START;
                end
            end
            S_START: begin
                if (clk_cnt == CNT_MID) begin
                    clk_cnt_nxt = '0;
                    bit_cnt_nxt = '0;
                    state_nxt   = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (clk_cnt == CNT_LAST) begin
                    clk_cnt_nxt         = '0;
                    shift_nxt[bit_cnt]  = rx_s;
                    if (bit_cnt == 3'd7) begin
                        state_nxt = S_PARITY;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (clk_cnt == CNT_LAST) begin
                    clk_cnt_nxt = '0;
                    parity_nxt  = rx_s;
                    state_nxt   = S_STOP;
                end
            end
            S_STOP: begin
                // Returning to idle mid stop bit leaves half a bit to catch a
                // back-to-back start edge.
                if (clk_cnt == CNT_LAST) begin
                    clk_cnt_nxt = '0;
                    data_nxt    = shift_reg;
                    perr_nxt    = ((^shift_reg) ^ parity_bit) != PARITY_ODD;
                    ferr_nxt    = ~rx_s;
                    valid_nxt   = 1'b1;
                    state_nxt   = S_IDLE;
                end
            end
            default: begin
                state_nxt   = S_IDLE;
                clk_cnt_nxt = '0;
            end
        endcase
    end

    assign rx_busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_top.sv
// Directed bench for uart_rx_top: an even-parity and an odd-parity receiver
// share one serial line driven by a bit-accurate transmitter model.

module tb_uart_rx_top;

    localparam int C = 16;
    // Line edge to rx_valid: 2 synchroniser cycles, the IDLE detect cycle,
    // then half a start bit plus ten full bits.
    localparam int LAT = 2 + 1 + C / 2 + 10 * C;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_line = 1'b1;
    logic [7:0] rx_data_out, odd_data_out;
    logic       rx_valid, rx_parity_err, rx_frame_err, rx_busy;
    logic       odd_valid, odd_parity_err, odd_frame_err, odd_busy;

    uart_rx_top #(.CLKS_PER_BIT(C), .PARITY_ODD(1'b0)) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_data_in    (rx_line),
        .rx_data_out   (rx_data_out),
        .rx_valid      (rx_valid),
        .rx_parity_err (rx_parity_err),
        .rx_frame_err  (rx_frame_err),
        .rx_busy       (rx_busy)
    );

    uart_rx_top #(.CLKS_PER_BIT(C), .PARITY_ODD(1'b1)) dut_odd (
        .clk           (clk),
        .rst           (rst),
        .rx_data_in    (rx_line),
        .rx_data_out   (odd_data_out),
        .rx_valid      (odd_valid),
        .rx_parity_err (odd_parity_err),
        .rx_frame_err  (odd_frame_err),
        .rx_busy       (odd_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         valid_hi = 0, valid_rise = 0, busy_cyc = 0, odd_rise = 0;
    int         last_rise_cyc = 0, prev_rise_cyc = 0;
    logic       valid_d = 1'b0;
    logic [7:0] cap_data = 8'h00;
    logic       cap_perr = 1'b0, cap_ferr = 1'b0, odd_perr = 1'b0;

    always @(negedge clk) begin
        if (rx_valid) begin
            valid_hi++;
            if (!valid_d) begin
                valid_rise++;
                prev_rise_cyc = last_rise_cyc;
                last_rise_cyc = cyc;
                cap_data      = rx_data_out;
                cap_perr      = rx_parity_err;
                cap_ferr      = rx_frame_err;
            end
        end
        valid_d = rx_valid;
        if (rx_busy) busy_cyc++;
        if (odd_valid) begin
            odd_rise++;
            odd_perr = odd_parity_err;
        end
    end

    int n_total = 0, n_pass = 0, n_fail = 0;
    int frame_start_cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Transmitter model: start, data LSB first, parity, stop; C cycles per bit.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        logic [10:0] fb;
        fb = {s, p, d, 1'b0};
        frame_start_cyc = cyc;
        for (int i = 0; i < 11; i++) begin
            rx_line = fb[i];
            repeat (C) @(negedge clk);
        end
    endtask

    initial begin
        int v0, b0;
        logic [10:0] fb;
        logic [7:0]  tx_data_in;

        rx_line = 1'b1;
        rst     = 1'b1;
        idle(3);
        check("rst_data", 32'(rx_data_out), 32'h00);
        check("rst_flags", {29'd0, rx_valid, rx_parity_err, rx_frame_err}, 32'h0);
        rst = 1'b0;
        idle(100);
        check("idle_busy_cycles", busy_cyc, 0);
        check("idle_no_valid", valid_rise, 0);

        // Clean frame, even parity
        v0 = valid_rise;
        send_frame(8'hA5, 1'b0, 1'b1);
        idle(4);
        check("a5_count", valid_rise - v0, 1);
        check("a5_data", 32'(cap_data), 32'hA5);
        check("a5_perr", 32'(cap_perr), 32'h0);
        check("a5_ferr", 32'(cap_ferr), 32'h0);
        check("a5_latency", last_rise_cyc - frame_start_cyc, LAT);
        check("a5_odd_perr", 32'(odd_perr), 32'h1);

        // Parity error in even mode, clean in odd mode
        v0 = valid_rise;
        send_frame(8'h01, 1'b0, 1'b1);
        idle(4);
        check("p01_count", valid_rise - v0, 1);
        check("p01_data", 32'(cap_data), 32'h01);
        check("p01_perr", 32'(cap_perr), 32'h1);
        check("p01_ferr", 32'(cap_ferr), 32'h0);
        check("p01_odd_perr", 32'(odd_perr), 32'h0);
        idle(50);
        check("p01_perr_hold", 32'(rx_parity_err), 32'h1);

        // Framing error; line held low for the whole stop bit, then released
        v0 = valid_rise;
        send_frame(8'h3C, 1'b0, 1'b0);
        rx_line = 1'b1;
        idle(40);
        check("f3c_count", valid_rise - v0, 1);
        check("f3c_data", 32'(cap_data), 32'h3C);
        check("f3c_ferr", 32'(cap_ferr), 32'h1);
        check("f3c_perr", 32'(cap_perr), 32'h0);
        check("f3c_idle_after", 32'(rx_busy), 32'h0);

        // Short glitch: busy for exactly the half-bit start check, nothing else
        v0 = valid_rise;
        b0 = busy_cyc;
        rx_line = 1'b0;
        idle(5);
        rx_line = 1'b1;
        idle(30);
        check("glitch_busy_cycles", busy_cyc - b0, C / 2);
        check("glitch_no_valid", valid_rise - v0, 0);
        check("glitch_data_held", 32'(rx_data_out), 32'h3C);
        check("glitch_ferr_held", 32'(rx_frame_err), 32'h1);

        // Back-to-back frames
        v0 = valid_rise;
        send_frame(8'h55, 1'b0, 1'b1);
        check("b2b_first_data", 32'(cap_data), 32'h55);
        send_frame(8'hAA, 1'b0, 1'b1);
        idle(4);
        check("b2b_count", valid_rise - v0, 2);
        check("b2b_second_data", 32'(cap_data), 32'hAA);
        check("b2b_spacing", last_rise_cyc - prev_rise_cyc, 11 * C);
        check("b2b_flags", {30'd0, cap_perr, cap_ferr}, 32'h0);

        // Reset in the middle of data bit 4
        v0 = valid_rise;
        fb = {1'b1, 1'b0, 8'hC3, 1'b0};
        for (int i = 0; i < 5; i++) begin
            rx_line = fb[i];
            idle(C);
        end
        rx_line = fb[5];
        idle(C / 2);
        check("midrst_busy_before", 32'(rx_busy), 32'h1);
        rst     = 1'b1;
        rx_line = 1'b1;
        idle(3);
        check("midrst_data", 32'(rx_data_out), 32'h00);
        check("midrst_busy", 32'(rx_busy), 32'h0);
        rst = 1'b0;
        idle(12 * C);
        check("midrst_no_valid", valid_rise - v0, 0);
        check("midrst_data_after", 32'(rx_data_out), 32'h00);

        // Loopback of a transmitted byte with model-computed even parity
        v0 = valid_rise;
        tx_data_in = 8'hF0;
        send_frame(tx_data_in, ^tx_data_in, 1'b1);
        idle(4);
        check("loop_count", valid_rise - v0, 1);
        check("loop_data", 32'(cap_data), 32'hF0);
        check("loop_flags", {30'd0, cap_perr, cap_ferr}, 32'h0);

        check("total_frames", valid_rise, 6);
        check("valid_one_cycle", valid_hi, valid_rise);
        check("odd_frames", odd_rise, 6);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_rx_top.md
Name: uart_rx_top

Overview:
- Serial UART receiver; the receive-side counterpart of the UART transmit path.
- Deserialises frames of the form: start bit 0, 8 data bits LSB first, 1 parity bit, stop bit 1.
- Line sampling:
  - 2-flop synchroniser on the input.
  - Mid-bit sampling with a per-bit clock counter.
- Outputs: received byte with a one-cycle valid strobe, plus parity and framing error flags. Sits between the serial pin and the byte-level consumer.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit; must be even and >= 4.
- PARITY_ODD, 0, 0 = even parity (data XOR parity == 0); 1 = odd parity (data XOR parity == 1).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- rx_data_in  input  1  serial line; idle high; asynchronous to clk.
- rx_data_out  output  8  last received byte; held until the next frame completes.
- rx_valid  output  1  one-cycle pulse; rx_data_out/rx_parity_err/rx_frame_err are valid this cycle.
- rx_parity_err  output  1  parity mismatch on the frame reported with rx_valid.
- rx_frame_err  output  1  stop bit sampled 0 on the frame reported with rx_valid.
- rx_busy  output  1  high from start-bit detect until return to IDLE.

Behaviour:
- Reset:
  - Synchronous, active-high, has priority over everything.
  - rx_data_out=8'h00; rx_valid, rx_parity_err, rx_frame_err, rx_busy = 0.
  - Synchroniser flops = 1; state = IDLE; counters = 0.
  - Asserting rst mid-frame aborts the frame; no rx_valid is produced for it.
- Synchroniser: rx_s = rx_data_in delayed 2 clk. All FSM decisions use rx_s only.
- Counters:
  - clk_cnt counts 0..CLKS_PER_BIT-1.
  - bit_cnt counts 0..7.
- States IDLE, START, DATA, PARITY, STOP:
  - IDLE: rx_busy=0. On rx_s==0 go to START with clk_cnt=0 and rx_busy=1.
  - START: when clk_cnt==CLKS_PER_BIT/2-1 (mid start bit), sample rx_s.
    - 1: false start; return to IDLE, rx_busy=0, no flags change.
    - 0: clk_cnt=0, bit_cnt=0, go to DATA.
  - DATA: when clk_cnt==CLKS_PER_BIT-1, shift rx_s into bit[bit_cnt] (LSB first) and clear clk_cnt. After bit_cnt==7 is sampled, go to PARITY.
  - PARITY: at clk_cnt==CLKS_PER_BIT-1, capture the parity bit; go to STOP.
  - STOP: at clk_cnt==CLKS_PER_BIT-1, sample the stop bit.
    - In the same cycle, register the outputs:
      - rx_data_out = shift register.
      - rx_parity_err = (^data ^ parity) != PARITY_ODD.
      - rx_frame_err = ~stop.
      - rx_valid = 1.
    - Next state IDLE, rx_busy=0.
- rx_valid is high exactly one cycle. Error flags hold until the next rx_valid.
- A frame with an error still delivers its data with rx_valid=1.
- Frame timing: rx_valid asserts (CLKS_PER_BIT/2) + 10*CLKS_PER_BIT cycles after the cycle rx_s first reads 0, i.e. registered, in the cycle after the stop-bit sample edge.
- Back-to-back frames: IDLE is re-entered mid stop bit. A falling edge immediately after the stop bit is detected without a lost frame.
- Framing error recovery:
  - If the stop bit is 0 and the line stays low, IDLE sees rx_s==0 and starts a new frame.
  - This is the required behaviour; no break detection.
- Glitches shorter than CLKS_PER_BIT/2 cycles on an idle line cause a false start only. No outputs change.

Test Plan:
- Reset idle: hold rst 3 cycles, line high 100 cycles -> all outputs 0, rx_busy never asserts.
- Clean frame, even parity: send 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first), parity 0, stop 1, CLKS_PER_BIT=16 -> one rx_valid pulse; rx_data_out=8'hA5, both error flags 0; rx_valid 168 cycles after rx_s falls.
- Parity error: send 0x01 with parity 0 (even mode) -> rx_valid with rx_data_out=8'h01, rx_parity_err=1, rx_frame_err=0. With PARITY_ODD=1 the same frame gives rx_parity_err=0.
- Framing error: send 0x3C, correct parity 0, stop bit 0 -> rx_data_out=8'h3C, rx_frame_err=1.
- False start and back-to-back frames:
  - 5-cycle low glitch -> rx_busy pulses, no rx_valid.
  - Then 0x55 followed immediately by 0xAA -> two rx_valid pulses exactly 176 cycles apart, data 8'h55 then 8'hAA.
- Reset mid-frame and loopback:
  - Assert rst during DATA bit 4 -> outputs cleared, no rx_valid.
  - Line-accurate loopback from the transmitter with tx_data_in=8'hF0 -> rx_data_out=8'hF0, no errors.
